// File: rtl/mantissa_normalize_round.sv
// Renormalise and round-to-nearest-even the mantissa_add_sub result; one transaction in flight, valid/ready on both sides.
// Define MANTISSA_NORM_LZC_EN for a single-cycle leading-zero shift; otherwise left shifts are bit-serial.
module mantissa_normalize_round #(
  parameter int MANTISSA_WIDTH = 23,
  parameter int EXPONENT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MANTISSA_WIDTH+3:0]   in_mantissa,
  input  logic                        in_carry,
  input  logic [EXPONENT_WIDTH-1:0]   in_exponent,
  input  logic                        in_sign,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MANTISSA_WIDTH-1:0]   out_mantissa,
  output logic [EXPONENT_WIDTH-1:0]   out_exponent,
  output logic                        out_sign,
  output logic                        out_zero,
  output logic                        out_inexact,
  output logic                        out_underflow,
  output logic                        out_overflow
);

  localparam int MW  = MANTISSA_WIDTH;
  localparam int EW  = EXPONENT_WIDTH;
  localparam int WW  = MW + 5;
  localparam int EXW = EW + 1;
  localparam int HB  = MW + 3;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [WW-1:0]   r_w, w_w_nxt;
  logic [EXW-1:0]  r_e, w_e_nxt;
  logic            r_s, w_s_nxt;
  logic [MW-1:0]   r_mant, w_mant_nxt;
  logic [EW-1:0]   r_exp, w_exp_nxt;
  logic            r_zero, w_zero_nxt;
  logic            r_inexact, w_inexact_nxt;
  logic            r_underflow, w_underflow_nxt;
  logic            r_overflow, w_overflow_nxt;

  logic            w_inc;
  logic [MW+1:0]   w_sum;
  logic [MW:0]     w_m;
  logic [EXW-1:0]  w_e_rnd;
  logic            w_rnd_inexact;
  logic [EW-1:0]   w_exp_enc;
  logic            w_ovf;

  // Nearest-even: round up above half, or at exactly half when the kept LSB is odd.
  assign w_inc         = r_w[2] & (r_w[1] | r_w[0] | r_w[3]);
  assign w_sum         = {1'b0, r_w[HB:3]} + (MW+2)'(w_inc);
  assign w_m           = w_sum[MW+1] ? w_sum[MW+1:1] : w_sum[MW:0];
  assign w_e_rnd       = r_e + EXW'(w_sum[MW+1]);
  assign w_rnd_inexact = |r_w[2:0];
  assign w_exp_enc     = w_m[MW] ? w_e_rnd[EW-1:0] : '0;
  assign w_ovf         = (w_e_rnd >= {1'b0, {EW{1'b1}}});

`ifdef MANTISSA_NORM_LZC_EN
  logic [EXW-1:0]  w_lzc;
  logic [EXW-1:0]  w_emax1;
  logic [EXW-1:0]  w_shamt;

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i <= HB; i++) begin
      if (r_w[i]) w_lzc = EXW'(HB - i);
    end
  end

  // Never shift the exponent below 1; the remainder stays denormal.
  assign w_emax1 = r_e - EXW'(1);
  assign w_shamt = (w_lzc < w_emax1) ? w_lzc : w_emax1;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_w_nxt         = r_w;
    w_e_nxt         = r_e;
    w_s_nxt         = r_s;
    w_mant_nxt      = r_mant;
    w_exp_nxt       = r_exp;
    w_zero_nxt      = r_zero;
    w_inexact_nxt   = r_inexact;
    w_underflow_nxt = r_underflow;
    w_overflow_nxt  = r_overflow;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_w_nxt = {in_carry, in_mantissa};
          w_e_nxt = (in_exponent == '0) ? EXW'(1) : {1'b0, in_exponent};
          w_s_nxt = in_sign;
          if ({in_carry, in_mantissa} == '0) begin
            w_state_nxt     = DONE;
            w_mant_nxt      = '0;
            w_exp_nxt       = '0;
            w_zero_nxt      = 1'b1;
            w_inexact_nxt   = 1'b0;
            w_underflow_nxt = 1'b0;
            w_overflow_nxt  = 1'b0;
          end else begin
            w_state_nxt = NORM;
          end
        end
      end
      NORM: begin
        if (r_w[WW-1]) begin
          w_w_nxt     = {1'b0, r_w[WW-1:2], r_w[1] | r_w[0]};
          w_e_nxt     = r_e + EXW'(1);
          w_state_nxt = ROUND;
        end
`ifdef MANTISSA_NORM_LZC_EN
        else begin
          w_w_nxt     = r_w << w_shamt;
          w_e_nxt     = r_e - w_shamt;
          w_state_nxt = ROUND;
        end
`else
        else if (r_w[HB]) begin
          w_state_nxt = ROUND;
        end else if (r_e == EXW'(1)) begin
          w_state_nxt = ROUND;
        end else begin
          w_w_nxt = r_w << 1;
          w_e_nxt = r_e - EXW'(1);
        end
`endif
      end
      ROUND: begin
        w_e_nxt     = w_e_rnd;
        w_zero_nxt  = 1'b0;
        w_state_nxt = DONE;
        if (w_ovf) begin
          w_mant_nxt      = '0;
          w_exp_nxt       = '1;
          w_inexact_nxt   = 1'b1;
          w_underflow_nxt = 1'b0;
          w_overflow_nxt  = 1'b1;
        end else begin
          w_mant_nxt      = w_m[MW-1:0];
          w_exp_nxt       = w_exp_enc;
          w_inexact_nxt   = w_rnd_inexact;
          w_underflow_nxt = (w_exp_enc == '0) & (w_m != '0) & w_rnd_inexact;
          w_overflow_nxt  = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_w         <= '0;
      r_e         <= '0;
      r_s         <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_zero      <= 1'b0;
      r_inexact   <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_w         <= w_w_nxt;
      r_e         <= w_e_nxt;
      r_s         <= w_s_nxt;
      r_mant      <= w_mant_nxt;
      r_exp       <= w_exp_nxt;
      r_zero      <= w_zero_nxt;
      r_inexact   <= w_inexact_nxt;
      r_underflow <= w_underflow_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign out_valid     = (r_state == DONE);
  assign out_mantissa  = r_mant;
  assign out_exponent  = r_exp;
  assign out_sign      = r_s;
  assign out_zero      = r_zero;
  assign out_inexact   = r_inexact;
  assign out_underflow = r_underflow;
  assign out_overflow  = r_overflow;

endmodule

// File: tb/tb_mantissa_normalize_round.sv
// Self-checking bench for mantissa_normalize_round: directed vector table, reset/backpressure sequences, random vs reference model.
module tb_mantissa_normalize_round;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_mantissa;
  logic        in_carry;
  logic [7:0]  in_exponent;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_mantissa;
  logic [7:0]  out_exponent;
  logic        out_sign;
  logic        out_zero;
  logic        out_inexact;
  logic        out_underflow;
  logic        out_overflow;

  always #5 clk = ~clk;

  mantissa_normalize_round #(.MANTISSA_WIDTH(23), .EXPONENT_WIDTH(8)) dut (
    .clk(clk), .arst_n(arst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mantissa(in_mantissa), .in_carry(in_carry),
    .in_exponent(in_exponent), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mantissa(out_mantissa), .out_exponent(out_exponent), .out_sign(out_sign),
    .out_zero(out_zero), .out_inexact(out_inexact),
    .out_underflow(out_underflow), .out_overflow(out_overflow)
  );

  typedef struct {
    logic [22:0] mant;
    logic [7:0]  expo;
    logic        sign;
    logic        zero;
    logic        inexact;
    logic        underflow;
    logic        overflow;
    int          lat;
  } res_t;

  typedef struct {
    logic        c;
    logic [26:0] m;
    logic [7:0]  ex;
    logic        s;
    int          stall;
    logic [22:0] mant;
    logic [7:0]  expo;
    logic        zero;
    logic        inx;
    logic        unf;
    logic        ovf;
    int          lat;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Value-level reference: real-valued normalisation then nearest-even on the remainder.
  function automatic res_t model(input logic c, input logic [26:0] m, input logic [7:0] ex, input logic s);
    res_t   r;
    longint v, q, rem;
    int     e, shifts;
    r = '{default: 0};
    r.sign = s;
    v = 0;
    v[27:0] = {c, m};
    e = (ex == 0) ? 1 : int'(ex);
    if (v == 0) begin
      r.zero = 1'b1;
      r.lat  = 1;
      return r;
    end
    shifts = 0;
    if (v >= (longint'(1) << 27)) begin
      v = (v >> 1) | (v & 1);
      e++;
    end else begin
      while (v < (longint'(1) << 26) && e > 1) begin
        v = v << 1;
        e--;
        shifts++;
      end
    end
    q   = v >> 3;
    rem = v & 7;
    if (rem > 4 || (rem == 4 && q[0])) q++;
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    r.inexact = (rem != 0);
    if (e >= 255) begin
      r.overflow = 1'b1;
      r.inexact  = 1'b1;
      r.expo     = 8'hFF;
      r.mant     = '0;
    end else begin
      r.mant      = q[22:0];
      r.expo      = (q >= (longint'(1) << 23)) ? 8'(e) : 8'h00;
      r.underflow = (r.expo == 0) && (q != 0) && r.inexact;
    end
`ifdef MANTISSA_NORM_LZC_EN
    r.lat = 3;
`else
    r.lat = 3 + shifts;
`endif
    return r;
  endfunction

  task automatic pulse_reset();
    arst_n = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input res_t r);
    chk({tag, " mant"},  out_mantissa,  r.mant);
    chk({tag, " exp"},   out_exponent,  r.expo);
    chk({tag, " sign"},  out_sign,      r.sign);
    chk({tag, " zero"},  out_zero,      r.zero);
    chk({tag, " inx"},   out_inexact,   r.inexact);
    chk({tag, " unf"},   out_underflow, r.underflow);
    chk({tag, " ovf"},   out_overflow,  r.overflow);
  endtask

  task automatic run_txn(input string tag, input logic c, input logic [26:0] m,
                         input logic [7:0] ex, input logic s, input int stall, input res_t r);
    int lat;
    bit seen;
    @(negedge clk);
    chk({tag, " idle_rdy"}, in_ready, 1'b1);
    in_valid    = 1'b1;
    in_carry    = c;
    in_mantissa = m;
    in_exponent = ex;
    in_sign     = s;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_carry    = 1'($urandom);
    in_mantissa = 27'($urandom);
    in_exponent = 8'($urandom);
    in_sign     = 1'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (lat < 100 && !seen) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, " busy_rdy"}, in_ready, 1'b0);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: out_valid not seen within %0d cycles", tag, lat);
      pulse_reset();
      return;
    end
    chk({tag, " latency"}, lat, r.lat);
    check_out(tag, r);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, " stall_vld"}, out_valid, 1'b1);
      chk({tag, " stall_rdy"}, in_ready, 1'b0);
    end
    if (stall > 0) check_out({tag, " held"}, r);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " post_vld"}, out_valid, 1'b0);
    chk({tag, " post_rdy"}, in_ready, 1'b1);
  endtask

  vec_t tbl[10];

  initial begin
    res_t        r;
    logic        c, s;
    logic [26:0] m;
    logic [7:0]  ex;
    logic [27:0] mask;
    int          k;
    bit          any_vld;

    //          c     m             ex      s     st  mant        exp     z     inx   unf   ovf   lat
    tbl[0] = '{1'b1, 27'h0000000, 8'd10,  1'b0, 0, 23'h000000, 8'd11,  1'b0, 1'b0, 1'b0, 1'b0, 3};
    tbl[1] = '{1'b0, 27'h0000008, 8'd100, 1'b0, 0, 23'h000000, 8'd77,  1'b0, 1'b0, 1'b0, 1'b0, 26};
    tbl[2] = '{1'b0, 27'h0000000, 8'd50,  1'b1, 0, 23'h000000, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[3] = '{1'b0, 27'h400000C, 8'd127, 1'b1, 0, 23'h000002, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[4] = '{1'b0, 27'h4000004, 8'd127, 1'b0, 0, 23'h000000, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[5] = '{1'b1, 27'h0000000, 8'd254, 1'b0, 0, 23'h000000, 8'hFF,  1'b0, 1'b1, 1'b0, 1'b1, 3};
    tbl[6] = '{1'b0, 27'h0000010, 8'd3,   1'b0, 5, 23'h000008, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 5};
    tbl[7] = '{1'b0, 27'h3FFFFFC, 8'd1,   1'b0, 0, 23'h000000, 8'd1,   1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[8] = '{1'b0, 27'h0000014, 8'd1,   1'b1, 2, 23'h000002, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 3};
    tbl[9] = '{1'b0, 27'h7FFFFFC, 8'd10,  1'b0, 0, 23'h000000, 8'd11,  1'b0, 1'b1, 1'b0, 1'b0, 3};

    arst_n      = 1'b0;
    in_valid    = 1'b0;
    in_carry    = 1'b0;
    in_mantissa = '0;
    in_exponent = '0;
    in_sign     = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready",  in_ready,      1'b1);
    chk("reset out_valid", out_valid,     1'b0);
    chk("reset mant",      out_mantissa,  23'h0);
    chk("reset exp",       out_exponent,  8'h0);
    chk("reset flags",     {out_zero, out_inexact, out_underflow, out_overflow, out_sign}, 5'b0);

    for (int i = 0; i < 10; i++) begin
      r.mant      = tbl[i].mant;
      r.expo      = tbl[i].expo;
      r.sign      = tbl[i].s;
      r.zero      = tbl[i].zero;
      r.inexact   = tbl[i].inx;
      r.underflow = tbl[i].unf;
      r.overflow  = tbl[i].ovf;
`ifdef MANTISSA_NORM_LZC_EN
      r.lat = tbl[i].zero ? 1 : 3;
`else
      r.lat = tbl[i].lat;
`endif
      run_txn($sformatf("vec%0d", i), tbl[i].c, tbl[i].m, tbl[i].ex, tbl[i].s, tbl[i].stall, r);
    end

    // Reset while the long cancellation is still normalising.
    @(negedge clk);
    in_valid    = 1'b1;
    in_carry    = 1'b0;
    in_mantissa = 27'h0000008;
    in_exponent = 8'd100;
    in_sign     = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    chk("midrst in_ready",  in_ready,  1'b1);
    chk("midrst out_valid", out_valid, 1'b0);
    any_vld = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) any_vld = 1'b1;
    end
    chk("midrst stays idle", any_vld, 1'b0);
    r = model(1'b0, 27'h400000C, 8'd127, 1'b0);
    run_txn("after_rst", 1'b0, 27'h400000C, 8'd127, 1'b0, 0, r);

    for (int n = 0; n < 150; n++) begin
      c = ($urandom_range(0, 3) == 0);
      if (c) begin
        m = 27'($urandom);
      end else begin
        k    = $urandom_range(0, 27);
        mask = (28'd1 << k) - 28'd1;
        m    = 27'($urandom) & mask[26:0];
      end
      if ($urandom_range(0, 15) == 0) begin
        c = 1'b0;
        m = '0;
      end
      ex = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      s  = 1'($urandom);
      r  = model(c, m, ex, s);
      run_txn($sformatf("rnd%0d", n), c, m, ex, s, $urandom_range(0, 2), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mantissa_normalize_round.md
Name: mantissa_normalize_round

Overview:
Downstream stage of mantissa_add_sub in the FPU datapath. Consumes the registered {carry_out, result} sum/difference with its sign and pre-normalisation exponent. Renormalises with a right shift on carry or bit-serial left shifts after cancellation, with denormal clamping. Rounds to nearest-even and emits the packed fraction/exponent to the pack stage over a valid/ready handshake.

Parameters:
MANTISSA_WIDTH, 23, fraction bits; input mantissa is MANTISSA_WIDTH+4 bits = {hidden, fraction, G, R, S}
EXPONENT_WIDTH, 8, biased exponent field width

Ports:
clk  in  1  clock
arst_n  in  1  reset; active-low, synchronous
in_valid  in  1  input transaction valid
in_ready  out  1  stage can accept; high only in IDLE
in_mantissa  in  MANTISSA_WIDTH+4  mantissa_add_sub result
in_carry  in  1  mantissa_add_sub carry_out
in_exponent  in  EXPONENT_WIDTH  biased exponent of aligned operands
in_sign  in  1  result sign
out_valid  out  1  output valid
out_ready  in  1  downstream accepts
out_mantissa  out  MANTISSA_WIDTH  rounded fraction, hidden bit dropped
out_exponent  out  EXPONENT_WIDTH  encoded biased exponent
out_sign  out  1  result sign
out_zero, out_inexact, out_underflow, out_overflow  out  1 each  status flags

Behaviour:
- Interface: one clock; reset is synchronous and active-low. All state changes on posedge clk. Reset has priority: state IDLE, all registered outputs 0, any in-flight transaction dropped. in_ready = (state==IDLE), so it is 1 out of reset.
- Working regs: W [MANTISSA_WIDTH+4:0], E [EXPONENT_WIDTH:0] (one spare bit), S.
- Accept (IDLE, in_valid): W={in_carry,in_mantissa}; E = (in_exponent==0) ? 1 : in_exponent; S=in_sign. If W==0 go DONE with zero result, else go NORM.
- NORM, evaluated once per cycle in priority order:
  1. If W[top] (carry): W={0,W[top:2],W[1]|W[0]} (sticky kept); E+=1; go ROUND.
  2. Else if hidden bit W[MANTISSA_WIDTH+3] set: go ROUND.
  3. Else if E==1: denormal, stop shifting; go ROUND.
  4. Else: W<<=1, zero fill; E-=1; stay in NORM.
- ROUND (1 cycle):
  - L=W[3], G=W[2], R=W[1], St=W[0]; inc=G&(R|St|L).
  - M=W[MANTISSA_WIDTH+3:3]+inc. If M overflows MANTISSA_WIDTH+1 bits: M>>=1, E+=1.
  - inexact=G|R|St.
  - Encoded exponent = hidden(M) ? E : 0. A denormal that rounds up into the hidden bit encodes E=1.
  - If E >= 2^EXPONENT_WIDTH-1: out_exponent all-ones, out_mantissa 0, out_overflow=1, out_inexact=1.
  - out_underflow = (encoded exp==0) & (M!=0) & inexact.
  - Go DONE.
- DONE: out_valid=1. All out_* held stable until out_ready; on out_valid&out_ready go IDLE, out_valid=0 next cycle. No input is accepted in the same cycle.
- Zero result: out_mantissa=0, out_exponent=0, out_zero=1, out_sign=captured sign, all other flags 0.
- Latency with no left shift: out_valid high 3 cycles after the accept edge. Each left shift adds 1 cycle; worst case is MANTISSA_WIDTH+3 extra. Zero input: out_valid high 1 cycle after accept.
- Throughput: one transaction in flight; next accept no earlier than the cycle after the output handshake.

Optional Feature:
MANTISSA_NORM_LZC_EN
- Defined: NORM computes a leading-zero count and applies shift = min(lzc, E-1) in a single cycle, so NORM always lasts exactly 1 cycle and latency is fixed at 3 (zero input: 1).
- Undefined: bit-serial left shift as above.
- Output values and flags are identical in both builds; only latency differs.

Test Plan:
All cases use defaults (MANTISSA_WIDTH=23, EXPONENT_WIDTH=8).
1. Carry renormalise: in_carry=1, in_mantissa=27'h0, in_exponent=10, in_sign=0 -> out_exponent=11, out_mantissa=0, all flags 0, out_valid 3 cycles after accept.
2. Cancellation: in_mantissa=27'h0000008, in_exponent=100 -> 23 left shifts; out_exponent=77, out_mantissa=0, out_valid 26 cycles after accept (3 cycles with MANTISSA_NORM_LZC_EN).
3. Zero: in_carry=0, in_mantissa=0, in_exponent=50, in_sign=1 -> out_zero=1, out_exponent=0, out_mantissa=0, out_sign=1, out_valid 1 cycle after accept.
4. Round to nearest-even, both cases with in_exponent=127:
   - in_mantissa=27'h400000C (L=1, GRS=100) -> out_mantissa=23'h000002, out_inexact=1.
   - in_mantissa=27'h4000004 (L=0, GRS=100) -> out_mantissa=23'h000000, out_inexact=1.
5. Overflow: in_carry=1, in_mantissa=0, in_exponent=254 -> out_exponent=8'hFF, out_mantissa=0, out_overflow=1, out_inexact=1.
6. Denormal plus backpressure: in_mantissa=27'h0000010, in_exponent=3, out_ready held low 5 cycles -> out_exponent=0, out_mantissa=23'h000008, out_underflow=0. Outputs stable and in_ready=0 while stalled. Asserting arst_n low for one cycle mid-NORM returns the block to IDLE with out_valid=0.
